// File: rtl/washer_plant_model_if.sv
// Actuator/sensor bundle between the washer controller and the plant model.
// Handshake: none. Every signal is a level that is sampled on each rising clk
// edge; there is no valid/ready pair, so each value is taken as meaningful on
// every cycle.
interface washer_plant_model_if #(
    parameter int LEVEL_W = 8
);
    // Controller actuators
    logic               quick_wash;
    logic               door_lock;
    logic               fill_valve_on;
    logic               water_wash;
    logic               soap_wash;
    logic               motor_on;
    logic               drain_valve_on;
    logic               done;
    // Plant sensors and observation outputs
    logic               filled;
    logic               drained;
    logic               detergent_added;
    logic               cycle_time_out;
    logic               spin_time_out;
    logic [LEVEL_W-1:0] water_level;
    logic [2:0]         phase;
    logic               fault;

    // Controller side: drives actuators, reads sensors
    modport master (
        output quick_wash, door_lock, fill_valve_on, water_wash, soap_wash,
               motor_on, drain_valve_on, done,
        input  filled, drained, detergent_added, cycle_time_out, spin_time_out,
               water_level, phase, fault
    );

    // Plant side: reads actuators, drives sensors
    modport slave (
        input  quick_wash, door_lock, fill_valve_on, water_wash, soap_wash,
               motor_on, drain_valve_on, done,
        output filled, drained, detergent_added, cycle_time_out, spin_time_out,
               water_level, phase, fault
    );
endinterface

// File: rtl/washer_plant_model.sv
// Washing-machine plant model: turns controller actuator levels into sensor
// inputs using a water-tank level register, wash and spin timers, a detergent
// dispenser delay counter, a sticky illegal-actuation flag and a phase decode.
module washer_plant_model #(
    parameter int LEVEL_W       = 8,
    parameter int FILL_LEVEL    = 20,
    parameter int FILL_RATE     = 1,
    parameter int DRAIN_RATE    = 2,
    parameter int TIMER_W       = 16,
    parameter int NORMAL_CYCLES = 40,
    parameter int QUICK_CYCLES  = 16,
    parameter int SPIN_CYCLES   = 12,
    parameter int DET_DELAY     = 3
) (
    input logic                 clk,
    input logic                 rst,
    washer_plant_model_if.slave bus
);

    localparam int DET_W = (DET_DELAY < 1) ? 1 : $clog2(DET_DELAY + 1);

    localparam logic [LEVEL_W:0]   FULL_X     = (LEVEL_W+1)'(FILL_LEVEL);
    localparam logic [LEVEL_W-1:0] FULL_L     = LEVEL_W'(FILL_LEVEL);
    localparam logic [LEVEL_W:0]   FILL_STEP  = (LEVEL_W+1)'(FILL_RATE);
    localparam logic [LEVEL_W-1:0] DRAIN_STEP = LEVEL_W'(DRAIN_RATE);
    localparam logic [TIMER_W-1:0] NORMAL_T   = TIMER_W'(NORMAL_CYCLES);
    localparam logic [TIMER_W-1:0] QUICK_T    = TIMER_W'(QUICK_CYCLES);
    localparam logic [TIMER_W-1:0] SPIN_T     = TIMER_W'(SPIN_CYCLES);
    localparam logic [DET_W-1:0]   DET_MAX    = DET_W'(DET_DELAY);
    localparam logic [DET_W-1:0]   DET_ONE    = DET_W'(1);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5
    } phase_t;

    logic [LEVEL_W-1:0] level_q, level_nx;
    logic [LEVEL_W:0]   level_up;

    logic [TIMER_W-1:0] wash_cnt, wash_tgt, wash_tgt_eff, wash_cnt_nx;
    logic               wash_run, cto_q;

    logic [TIMER_W-1:0] spin_cnt, spin_cnt_nx;
    logic               spin_run, sto_q;

    logic [DET_W-1:0]   det_cnt, det_cnt_nx;
    logic               soap_q, soap_rise, det_q;

    logic               fault_q, illegal;
    phase_t             phase_q;

    // Next tank level: saturating fill, floor-at-zero drain, hold when both or neither
    always_comb begin
        level_up = {1'b0, level_q} + FILL_STEP;
        level_nx = level_q;
        if (bus.fill_valve_on && !bus.drain_valve_on) begin
            level_nx = (level_up >= FULL_X) ? FULL_L : level_up[LEVEL_W-1:0];
        end else if (bus.drain_valve_on && !bus.fill_valve_on) begin
            level_nx = (level_q >= DRAIN_STEP) ? (level_q - DRAIN_STEP) : '0;
        end
    end

    // Tank level register
    always_ff @(posedge clk) begin
        if (!rst) level_q <= '0;
        else      level_q <= level_nx;
    end

    // Wash timer next-count; the target is taken live on the first counting cycle
    always_comb begin
        wash_run     = bus.motor_on && !bus.drain_valve_on && (bus.water_wash || bus.soap_wash);
        wash_tgt_eff = (wash_cnt == '0) ? (bus.quick_wash ? QUICK_T : NORMAL_T) : wash_tgt;
        wash_cnt_nx  = (wash_cnt != wash_tgt_eff) ? (wash_cnt + 1'b1) : wash_cnt;
    end

    // Wash timer: counts while washing, saturates at target, clears when motor stops
    always_ff @(posedge clk) begin
        if (!rst) begin
            wash_cnt <= '0;
            wash_tgt <= '0;
            cto_q    <= 1'b0;
        end else if (bus.done || !bus.motor_on) begin
            wash_cnt <= '0;
            cto_q    <= 1'b0;
        end else if (wash_run) begin
            if (wash_cnt == '0) wash_tgt <= wash_tgt_eff;
            wash_cnt <= wash_cnt_nx;
            cto_q    <= (wash_cnt_nx == wash_tgt_eff);
        end
    end

    // Spin timer next-count
    always_comb begin
        spin_run    = bus.motor_on && bus.drain_valve_on;
        spin_cnt_nx = (spin_cnt != SPIN_T) ? (spin_cnt + 1'b1) : spin_cnt;
    end

    // Spin timer: counts while motor and drain are both on, holds at SPIN_CYCLES
    always_ff @(posedge clk) begin
        if (!rst || bus.done || !spin_run) begin
            spin_cnt <= '0;
            sto_q    <= 1'b0;
        end else begin
            spin_cnt <= spin_cnt_nx;
            sto_q    <= (spin_cnt_nx == SPIN_T);
        end
    end

    // Dispenser next-count: a soap rising edge loads 1, then counts up to DET_DELAY
    always_comb begin
        soap_rise = bus.soap_wash && !soap_q;
        if (soap_rise) begin
            det_cnt_nx = DET_ONE;
        end else if ((det_cnt != '0) && (det_cnt != DET_MAX)) begin
            det_cnt_nx = det_cnt + 1'b1;
        end else begin
            det_cnt_nx = det_cnt;
        end
    end

    // Detergent dispenser: flag rises DET_DELAY edges after soap rises, drops with soap
    always_ff @(posedge clk) begin
        if (!rst) soap_q <= 1'b0;
        else      soap_q <= bus.soap_wash;

        if (!rst || bus.done || !bus.soap_wash) begin
            det_cnt <= '0;
            det_q   <= 1'b0;
        end else begin
            det_cnt <= det_cnt_nx;
            det_q   <= (det_cnt_nx == DET_MAX);
        end
    end

    assign illegal = (bus.fill_valve_on && bus.drain_valve_on) ||
                     (bus.motor_on && !bus.door_lock) ||
                     (bus.fill_valve_on && !bus.door_lock);

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst)         fault_q <= 1'b0;
        else if (illegal) fault_q <= 1'b1;
    end

    // Registered phase decode in priority order
    always_ff @(posedge clk) begin
        if (!rst)                                  phase_q <= PH_IDLE;
        else if (bus.done)                         phase_q <= PH_DONE;
        else if (bus.motor_on && bus.drain_valve_on) phase_q <= PH_SPIN;
        else if (bus.drain_valve_on)               phase_q <= PH_DRAIN;
        else if (bus.motor_on)                     phase_q <= PH_WASH;
        else if (bus.fill_valve_on)                phase_q <= PH_FILL;
        else                                       phase_q <= PH_IDLE;
    end

    assign bus.water_level     = level_q;
    assign bus.filled          = (level_q == FULL_L);
    assign bus.drained         = (level_q == '0);
    assign bus.detergent_added = det_q;
    assign bus.cycle_time_out  = cto_q;
    assign bus.spin_time_out   = sto_q;
    assign bus.phase           = phase_q;
    assign bus.fault           = fault_q;

endmodule
